// File: rtl/pipe_chk_pkg.sv
// Shared definitions for the pipeline stream checker: FSM state encoding and
// the channel-index width helper.
package pipe_chk_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One extra bit so a single-channel build still has a 1-bit index port.
    function automatic int ch_idx_w(input int num_ch);
        return $clog2(num_ch) + 1;
    endfunction

endpackage

// File: rtl/chk_lane.sv
// One checker lane: tracks the expected next value of a single channel, counts
// its valid beats and detects idle stretches long enough to count as a stall.
module chk_lane #(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int START_VAL = 0,
    parameter int STEP      = 1,
    parameter int STALL_LIM = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    output logic              mismatch,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              stall_flag
);
    localparam int IDLE_W = $clog2(STALL_LIM + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(STALL_LIM);
    localparam logic [DATA_W-1:0] START_V  = DATA_W'(START_VAL);
    localparam logic [DATA_W-1:0] STEP_V   = DATA_W'(STEP);

    logic [DATA_W-1:0] expected;
    logic [IDLE_W-1:0] idle_cnt;

    assign mismatch = en && valid && (data != expected);

    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            expected   <= START_V;
            beat_cnt   <= '0;
            idle_cnt   <= '0;
            stall_flag <= 1'b0;
        end else if (clr) begin
            expected   <= START_V;
            beat_cnt   <= '0;
            idle_cnt   <= '0;
            stall_flag <= 1'b0;
        end else if (en) begin
            if (valid) begin
                if (!(&beat_cnt))
                    beat_cnt <= beat_cnt + 1'b1;
                // Resync on the observed value so one bad beat is one error.
                expected <= data + STEP_V;
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_LIM) begin
                idle_cnt <= idle_cnt + 1'b1;
                if (idle_cnt == IDLE_LIM - 1'b1)
                    stall_flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_stream_checker.sv
// N-channel output checker for the global-stall pipeline: per-lane sequence
// checks, optional lock-step compare, error aggregation over a fixed window.
module pipe_stream_checker
    import pipe_chk_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int CYC_W      = 13,
    parameter int NUM_CYCLES = 8192,
    parameter int START_VAL  = 0,
    parameter int STEP       = 1,
    parameter int STALL_LIM  = 64,
    parameter int LOCKSTEP   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_CH-1:0]             in_valid,
    input  logic [NUM_CH*DATA_W-1:0]      in_data,
    output logic [NUM_CH*CNT_W-1:0]       beat_cnt,
    output logic [CNT_W-1:0]              err_cnt,
    output logic                          err_flag,
    output logic [ch_idx_w(NUM_CH)-1:0]   first_err_ch,
    output logic [CYC_W-1:0]              first_err_cycle,
    output logic [NUM_CH-1:0]             stall_flag,
    output logic                          done
);
    localparam int CH_W = ch_idx_w(NUM_CH);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(NUM_CYCLES - 1);

    logic [1:0]        state;
    logic [CYC_W-1:0]  cycle;
    logic              en;
    logic [NUM_CH-1:0] lane_err;
    logic [NUM_CH-1:0] lock_err;
    logic [NUM_CH-1:0] ch_err;
    logic [CH_W-1:0]   first_idx;

    // A start pulse wins over checking: that cycle's inputs are discarded.
    assign en   = (state == ST_RUN) && !start;
    assign done = (state == ST_DONE);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        chk_lane #(
            .DATA_W    (DATA_W),
            .CNT_W     (CNT_W),
            .START_VAL (START_VAL),
            .STEP      (STEP),
            .STALL_LIM (STALL_LIM)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .clr        (start),
            .en         (en),
            .valid      (in_valid[k]),
            .data       (in_data[k*DATA_W +: DATA_W]),
            .mismatch   (lane_err[k]),
            .beat_cnt   (beat_cnt[k*CNT_W +: CNT_W]),
            .stall_flag (stall_flag[k])
        );
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        lock_err = '0;
        if (LOCKSTEP != 0 && en) begin
            for (int k = 1; k < NUM_CH; k++) begin
                if (in_valid[k] != in_valid[0])
                    lock_err[k] = 1'b1;
                else if (in_valid[k] && in_data[k*DATA_W +: DATA_W] != in_data[0 +: DATA_W])
                    lock_err[k] = 1'b1;
            end
        end
    end

    assign ch_err = lane_err | lock_err;

    // Descending scan so the lowest erroring channel is written last.
    always_comb begin
        first_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_err[k])
                first_idx = CH_W'(k);
        end
    end

    // NOTE: only control and result registers take the async reset; there is
    // no memory here, so every state element returns to a known value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            cycle           <= '0;
            err_cnt         <= '0;
            err_flag        <= 1'b0;
            first_err_ch    <= '0;
            first_err_cycle <= '0;
        end else if (start) begin
            state           <= ST_RUN;
            cycle           <= '0;
            err_cnt         <= '0;
            err_flag        <= 1'b0;
            first_err_ch    <= '0;
            first_err_cycle <= '0;
        end else if (state == ST_RUN) begin
            if (|ch_err) begin
                if (!(&err_cnt))
                    err_cnt <= err_cnt + 1'b1;
                err_flag <= 1'b1;
                if (!err_flag) begin
                    first_err_ch    <= first_idx;
                    first_err_cycle <= cycle;
                end
            end
            if (cycle == LAST_CYC)
                state <= ST_DONE;
            else
                cycle <= cycle + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stream_checker.sv
// Directed bench: a default-parameter checker (32-bit, lock-step) and a small
// 4-bit, free-running checker used for wrap, resync and end-of-window cases.
module tb_pipe_stream_checker;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance a: default parameters.
    logic        a_start = 1'b0;
    logic [1:0]  a_valid = '0;
    logic [63:0] a_data  = '0;
    logic [31:0] a_beat_cnt;
    logic [15:0] a_err_cnt;
    logic        a_err_flag;
    logic [1:0]  a_first_err_ch;
    logic [12:0] a_first_err_cycle;
    logic [1:0]  a_stall_flag;
    logic        a_done;

    pipe_stream_checker u_a (
        .clk             (clk),
        .reset           (reset),
        .start           (a_start),
        .in_valid        (a_valid),
        .in_data         (a_data),
        .beat_cnt        (a_beat_cnt),
        .err_cnt         (a_err_cnt),
        .err_flag        (a_err_flag),
        .first_err_ch    (a_first_err_ch),
        .first_err_cycle (a_first_err_cycle),
        .stall_flag      (a_stall_flag),
        .done            (a_done)
    );

    // Instance b: 4-bit data starting at 14, 20-cycle window, stall limit 4.
    logic       b_start = 1'b0;
    logic [1:0] b_valid = '0;
    logic [7:0] b_data  = '0;
    logic [15:0] b_beat_cnt;
    logic [7:0] b_err_cnt;
    logic       b_err_flag;
    logic [1:0] b_first_err_ch;
    logic [4:0] b_first_err_cycle;
    logic [1:0] b_stall_flag;
    logic       b_done;

    pipe_stream_checker #(
        .NUM_CH     (2),
        .DATA_W     (4),
        .CNT_W      (8),
        .CYC_W      (5),
        .NUM_CYCLES (20),
        .START_VAL  (14),
        .STEP       (1),
        .STALL_LIM  (4),
        .LOCKSTEP   (0)
    ) u_b (
        .clk             (clk),
        .reset           (reset),
        .start           (b_start),
        .in_valid        (b_valid),
        .in_data         (b_data),
        .beat_cnt        (b_beat_cnt),
        .err_cnt         (b_err_cnt),
        .err_flag        (b_err_flag),
        .first_err_ch    (b_first_err_ch),
        .first_err_cycle (b_first_err_cycle),
        .stall_flag      (b_stall_flag),
        .done            (b_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
        a_valid = {v1, v0};
        a_data  = {d1, d0};
        tick();
    endtask

    task automatic drive_b(input logic v0, input logic [3:0] d0, input logic v1, input logic [3:0] d1);
        b_valid = {v1, v0};
        b_data  = {d1, d0};
        tick();
    endtask

    task automatic start_a();
        a_start = 1'b1;
        a_valid = '0;
        tick();
        a_start = 1'b0;
    endtask

    task automatic start_b();
        b_start = 1'b1;
        b_valid = '0;
        tick();
        b_start = 1'b0;
    endtask

    initial begin
        // Reset state.
        #2;
        check("rst_beat_a",  64'(a_beat_cnt), 64'h0);
        check("rst_err_a",   64'(a_err_cnt), 64'h0);
        check("rst_flag_a",  64'(a_err_flag), 64'h0);
        check("rst_done_a",  64'(a_done), 64'h0);
        check("rst_stall_a", 64'(a_stall_flag), 64'h0);
        check("rst_done_b",  64'(b_done), 64'h0);
        tick();
        reset = 1'b1;

        // Inputs ignored in IDLE.
        drive_a(1'b1, 32'd5, 1'b1, 32'd6);
        drive_a(1'b1, 32'd7, 1'b0, 32'd0);
        check("idle_beat_a", 64'(a_beat_cnt), 64'h0);
        check("idle_err_a",  64'(a_err_cnt), 64'h0);

        // Test 1: full clean window.
        start_a();
        for (int i = 0; i < 8192; i++) begin
            if (i == 8191)
                check("t1_done_early", 64'(a_done), 64'h0);
            drive_a(1'b1, 32'(i), 1'b1, 32'(i));
        end
        check("t1_done",   64'(a_done), 64'h1);
        check("t1_beat0",  64'(a_beat_cnt[15:0]), 64'd8192);
        check("t1_beat1",  64'(a_beat_cnt[31:16]), 64'd8192);
        check("t1_flag",   64'(a_err_flag), 64'h0);
        check("t1_errcnt", 64'(a_err_cnt), 64'h0);
        check("t1_stall",  64'(a_stall_flag), 64'h0);
        drive_a(1'b1, 32'd99, 1'b0, 32'd0);
        drive_a(1'b0, 32'd0, 1'b1, 32'd1);
        check("t1_hold_beat", 64'(a_beat_cnt), {32'h0, 16'd8192, 16'd8192});
        check("t1_hold_flag", 64'(a_err_flag), 64'h0);
        check("t1_hold_done", 64'(a_done), 64'h1);

        // Test 2: ch1 sends 9 instead of 5.
        start_a();
        check("t2_clr_beat", 64'(a_beat_cnt), 64'h0);
        check("t2_clr_done", 64'(a_done), 64'h0);
        for (int i = 0; i < 5; i++)
            drive_a(1'b1, 32'(i), 1'b1, 32'(i));
        check("t2_pre_flag", 64'(a_err_flag), 64'h0);
        drive_a(1'b1, 32'd5, 1'b1, 32'd9);
        check("t2_errcnt", 64'(a_err_cnt), 64'd1);
        check("t2_flag",   64'(a_err_flag), 64'h1);
        check("t2_ch",     64'(a_first_err_ch), 64'd1);
        check("t2_cyc",    64'(a_first_err_cycle), 64'd5);

        // Both channels err in the same cycle: lowest channel wins; resync.
        start_a();
        check("pr_clr_flag", 64'(a_err_flag), 64'h0);
        for (int i = 0; i < 3; i++)
            drive_a(1'b1, 32'(i), 1'b1, 32'(i));
        drive_a(1'b1, 32'd7, 1'b1, 32'd7);
        check("pr_ch",     64'(a_first_err_ch), 64'd0);
        check("pr_cyc",    64'(a_first_err_cycle), 64'd3);
        check("pr_errcnt", 64'(a_err_cnt), 64'd1);
        drive_a(1'b1, 32'd8, 1'b1, 32'd8);
        check("pr_resync", 64'(a_err_cnt), 64'd1);
        drive_a(1'b1, 32'd9, 1'b1, 32'd10);
        check("pr_err2",   64'(a_err_cnt), 64'd2);
        check("pr_keep_ch", 64'(a_first_err_ch), 64'd0);
        check("pr_keep_cyc", 64'(a_first_err_cycle), 64'd3);

        // Test 3: ch1 drops valid for one cycle at cycle 20.
        start_a();
        for (int i = 0; i < 20; i++)
            drive_a(1'b1, 32'(i), 1'b1, 32'(i));
        drive_a(1'b1, 32'd20, 1'b0, 32'd0);
        check("t3_errcnt", 64'(a_err_cnt), 64'd1);
        check("t3_ch",     64'(a_first_err_ch), 64'd1);
        check("t3_cyc",    64'(a_first_err_cycle), 64'd20);
        check("t3_beat",   64'(a_beat_cnt), {32'h0, 16'd20, 16'd21});

        // Test 4: ch0 idle for 64 cycles.
        start_a();
        for (int i = 0; i < 64; i++) begin
            if (i == 63)
                check("t4_stall_pre", 64'(a_stall_flag), 64'h0);
            drive_a(1'b0, 32'd0, 1'b1, 32'(i));
        end
        check("t4_stall",  64'(a_stall_flag), 64'h1);
        check("t4_errcnt", 64'(a_err_cnt), 64'd64);
        check("t4_cyc",    64'(a_first_err_cycle), 64'd0);
        for (int i = 64; i < 74; i++)
            drive_a(1'b0, 32'd0, 1'b1, 32'(i));
        drive_a(1'b1, 32'd0, 1'b1, 32'd74);
        check("t4_sticky", 64'(a_stall_flag), 64'h1);

        // Test 6: reset mid-run at cycle 100.
        start_a();
        for (int i = 0; i < 99; i++)
            drive_a(1'b1, 32'(i), 1'b1, 32'(i));
        drive_a(1'b1, 32'd99, 1'b1, 32'd500);
        check("t6_pre_beat", 64'(a_beat_cnt), {32'h0, 16'd100, 16'd100});
        check("t6_pre_flag", 64'(a_err_flag), 64'h1);
        reset = 1'b0;
        #1;
        check("t6_beat",  64'(a_beat_cnt), 64'h0);
        check("t6_err",   64'(a_err_cnt), 64'h0);
        check("t6_flag",  64'(a_err_flag), 64'h0);
        check("t6_first", 64'({a_first_err_ch, a_first_err_cycle}), 64'h0);
        check("t6_done",  64'(a_done), 64'h0);
        tick();
        reset = 1'b1;
        drive_a(1'b1, 32'd0, 1'b1, 32'd0);
        check("t6_idle_beat", 64'(a_beat_cnt), 64'h0);
        start_a();
        for (int i = 0; i < 3; i++)
            drive_a(1'b1, 32'(i), 1'b1, 32'(i));
        check("t6_re_beat", 64'(a_beat_cnt), {32'h0, 16'd3, 16'd3});
        check("t6_re_flag", 64'(a_err_flag), 64'h0);

        // Test 5 plus resync on the free-running 4-bit instance.
        start_b();
        drive_b(1'b1, 4'd14, 1'b1, 4'd14);
        drive_b(1'b1, 4'd15, 1'b1, 4'd15);
        drive_b(1'b1, 4'd0,  1'b1, 4'd0);
        check("t5_wrap", 64'(b_err_flag), 64'h0);
        drive_b(1'b1, 4'd1, 1'b1, 4'd5);
        check("t5_errcnt", 64'(b_err_cnt), 64'd1);
        check("t5_ch",     64'(b_first_err_ch), 64'd1);
        check("t5_cyc",    64'(b_first_err_cycle), 64'd3);
        drive_b(1'b1, 4'd2, 1'b1, 4'd6);
        check("t5_resync", 64'(b_err_cnt), 64'd1);
        for (int c = 5; c < 9; c++) begin
            if (c == 8)
                check("b_stall_pre", 64'(b_stall_flag), 64'h0);
            drive_b(1'b0, 4'd0, 1'b1, 4'(c + 2));
        end
        check("b_stall", 64'(b_stall_flag), 64'h1);
        for (int c = 9; c < 19; c++)
            drive_b(1'b0, 4'd0, 1'b1, 4'(c + 2));
        check("b_done_pre", 64'(b_done), 64'h0);
        check("b_err_pre",  64'(b_err_cnt), 64'd1);
        drive_b(1'b0, 4'd0, 1'b1, 4'd0);
        check("b_done",     64'(b_done), 64'h1);
        check("b_last_err", 64'(b_err_cnt), 64'd2);
        check("b_first_ch", 64'(b_first_err_ch), 64'd1);
        check("b_first_cyc", 64'(b_first_err_cycle), 64'd3);
        check("b_beat",     64'(b_beat_cnt), {48'h0, 8'd20, 8'd5});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
